// File: rtl/tmem_pkg.sv
// Shared types and sizing helpers for the tagged-RAM bus responder.
package tmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RPEND,
      LOCKRD,
      LOCKWR
   } mem_state_t;

   function automatic int tmem_lat_w(input int latency);
      return (latency < 1) ? 1 : $clog2(latency + 1);
   endfunction

   function automatic int tmem_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/tmem_array.sv
// Tagged word storage: one write port, one registered write-first read port.
// Contents are never reset so a bench can preload mem[] hierarchically.
module tmem_array
   import tmem_pkg::*;
#(
   parameter int DEPTH  = 1 << 20,
   parameter int WORD_W = 72,
   parameter int IDX_W  = tmem_idx_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   input  logic              rzero,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read register doubles as the held output word, so it carries the reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
      end else if (re) begin
         if (rzero)                     rdata <= '0;
         else if (we && waddr == raddr) rdata <= wdata;
         else                           rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/tmemory_ctrl.sv
// Tagged-RAM responder for the CPU memory bus: configurable geometry, read latency,
// busy back-pressure, address auto-increment and an atomic read-modify-write lock.
module tmemory_ctrl
   import tmem_pkg::*;
#(
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 64,
   parameter int TAG_W   = 8,
   parameter int DEPTH   = 1 << ADDR_W,
   parameter int LATENCY = 1,
   parameter int AUTOINC = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] ad,
   input  logic [TAG_W-1:0]  tag,
   input  logic              astb,
   input  logic              atomic,
   input  logic              rd,
   input  logic              wr,
   output logic [DATA_W-1:0] rdata,
   output logic [TAG_W-1:0]  rtag,
   output logic              rvalid,
   output logic              busy,
   output logic              locked,
   output logic [ADDR_W-1:0] waddr,
   output logic              err
);

   localparam int                LAT_W    = tmem_lat_w(LATENCY);
   localparam int                IDX_W    = tmem_idx_w(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LAST_V   = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [LAT_W-1:0]  CNT_INIT = LAT_W'(LATENCY - 1);

   mem_state_t                  state_q, state_d;
   logic [ADDR_W-1:0]           waddr_q, waddr_d, eff_addr;
   logic [LAT_W-1:0]            cnt_q, cnt_d;
   logic                        locked_q, locked_d;
   logic                        err_q, err_d;
   logic                        rvalid_q, rvalid_d;
   logic                        mem_we, mem_re, rd_zero;
   logic [DATA_W+TAG_W-1:0]     arr_q;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_V;
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} >= LAST_V) ? '0 : a + ADDR_W'(1);
   endfunction

   always_comb begin
      state_d  = state_q;
      waddr_d  = waddr_q;
      cnt_d    = cnt_q;
      locked_d = locked_q;
      err_d    = err_q;
      rvalid_d = 1'b0;
      mem_we   = 1'b0;
      mem_re   = 1'b0;
      eff_addr = waddr_q;
      case (state_q)
         IDLE: begin
            // A strobe in the same cycle redirects any accompanying rd/wr.
            if (astb) begin
               eff_addr = ad[ADDR_W-1:0];
               waddr_d  = eff_addr;
               if (atomic) begin
                  locked_d = 1'b1;
                  state_d  = LOCKRD;
               end
            end
            if (rd && wr) begin
               err_d = 1'b1;
            end else if (rd) begin
               state_d = RPEND;
               cnt_d   = CNT_INIT;
            end else if (wr) begin
               if (astb && atomic) begin
                  err_d = 1'b1;
               end else begin
                  mem_we = in_range(eff_addr);
                  if (!in_range(eff_addr)) err_d = 1'b1;
                  if (AUTOINC != 0) waddr_d = next_addr(eff_addr);
               end
            end
         end
         RPEND: begin
            if (astb || rd || wr) err_d = 1'b1;
            if (cnt_q == '0) begin
               mem_re   = 1'b1;
               rvalid_d = 1'b1;
               if (!in_range(waddr_q)) err_d = 1'b1;
               state_d  = locked_q ? LOCKWR : IDLE;
               if (AUTOINC != 0 && !locked_q) waddr_d = next_addr(waddr_q);
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
            end
         end
         LOCKRD: begin
            if (astb || wr) begin
               err_d = 1'b1;
            end else if (rd) begin
               state_d = RPEND;
               cnt_d   = CNT_INIT;
            end
         end
         LOCKWR: begin
            // Closing write of the RMW stays on the locked word: no increment.
            if (astb || rd) begin
               err_d = 1'b1;
            end else if (wr) begin
               mem_we   = in_range(waddr_q);
               if (!in_range(waddr_q)) err_d = 1'b1;
               locked_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         waddr_q  <= '0;
         cnt_q    <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         waddr_q  <= waddr_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rd_zero = !in_range(waddr_q);

   tmem_array #(
      .DEPTH  (DEPTH),
      .WORD_W (DATA_W + TAG_W),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (mem_we),
      .waddr   (eff_addr[IDX_W-1:0]),
      .wdata   ({ad, tag}),
      .re      (mem_re),
      .raddr   (waddr_q[IDX_W-1:0]),
      .rzero   (rd_zero),
      .rdata   (arr_q)
   );

   assign rdata  = arr_q[DATA_W+TAG_W-1:TAG_W];
   assign rtag   = arr_q[TAG_W-1:0];
   assign rvalid = rvalid_q;
   assign busy   = (state_q == RPEND);
   assign locked = locked_q;
   assign waddr  = waddr_q;
   assign err    = err_q;

endmodule
